// File: rtl/gpr_access_sequencer.sv
// Issue-side sequencer driving the GPR control pins for one decoded register operation at a time.
// Latency: simple/illegal op 1 cycle to done; ALU op 3 + (ALU_WAIT cycles before alu_done), or ALU_TIMEOUT + 2 on abort.
// Backpressure: req_ready high only in IDLE; requests presented while busy are neither accepted nor queued.
module gpr_access_sequencer #(
    parameter int unsigned ALU_TIMEOUT = 16,
    parameter logic [2:0]  MODE_READ   = 3'b001,
    parameter logic [2:0]  MODE_LOAD   = 3'b010,
    parameter logic [2:0]  MODE_ALU    = 3'b011,
    parameter logic [2:0]  MODE_MOVE   = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [2:0] req_src,
    input  logic [2:0] req_dst,
    input  logic       alu_done,
    output logic       gpr_enable,
    output logic [2:0] gpr_mode,
    output logic [2:0] gpr_src_addr,
    output logic [2:0] gpr_dst_addr,
    output logic       gpr_alu2in_enable,
    output logic       gpr_acc_enable,
    output logic       bus_load,
    output logic       bus_store,
    output logic       alu_start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [2:0] OP_ALU   = 3'b011;
    localparam logic [2:0] OP_NOP   = 3'b100;

    localparam logic [7:0] CNT_LAST = 8'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        ALU_ISSUE,
        ALU_WAIT,
        ACC_WB,
        ERR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cap_op;
    logic [2:0] cap_src;
    logic [2:0] cap_dst;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cap_op   <= 3'b000;
            cap_src  <= 3'b000;
            cap_dst  <= 3'b000;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (req_valid && state == IDLE) begin
                cap_op  <= req_op;
                cap_src <= req_src;
                cap_dst <= req_dst;
            end
            if (state == ALU_ISSUE) begin
                wait_cnt <= 8'd0;
            end else if (state == ALU_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Addresses come straight from the captured fields so they hold while IDLE.
    assign gpr_src_addr = cap_src;
    assign gpr_dst_addr = cap_dst;

    always_comb begin
        state_nxt         = state;
        req_ready         = 1'b0;
        busy              = 1'b1;
        gpr_enable        = 1'b0;
        gpr_mode          = 3'b000;
        gpr_alu2in_enable = 1'b0;
        gpr_acc_enable    = 1'b0;
        bus_load          = 1'b0;
        bus_store         = 1'b0;
        alu_start         = 1'b0;
        done              = 1'b0;
        err               = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (req_op == OP_ALU) begin
                        state_nxt = ALU_ISSUE;
                    end else if (req_op > OP_NOP) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                done      = 1'b1;
                state_nxt = IDLE;
                case (cap_op)
                    OP_LOAD: begin
                        gpr_enable = 1'b1;
                        gpr_mode   = MODE_LOAD;
                        bus_load   = 1'b1;
                    end
                    OP_STORE: begin
                        gpr_enable = 1'b1;
                        gpr_mode   = MODE_READ;
                        bus_store  = 1'b1;
                    end
                    OP_MOVE: begin
                        gpr_enable = 1'b1;
                        gpr_mode   = MODE_MOVE;
                    end
                    default: ;
                endcase
            end
            ALU_ISSUE: begin
                gpr_enable        = 1'b1;
                gpr_mode          = MODE_ALU;
                gpr_alu2in_enable = 1'b1;
                alu_start         = 1'b1;
                state_nxt         = ALU_WAIT;
            end
            ALU_WAIT: begin
                // Operands stay presented to the ALU; the GPR itself is not enabled.
                gpr_mode          = MODE_ALU;
                gpr_alu2in_enable = 1'b1;
                if (alu_done) begin
                    state_nxt = ACC_WB;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ERR;
                end
            end
            ACC_WB: begin
                gpr_acc_enable = 1'b1;
                done           = 1'b1;
                state_nxt      = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
